// File: rtl/ex_operand_stage_pkg.sv
// Shared constants and payload type for the DE->EX operand stage and its forwarding muxes.
package ex_operand_stage_pkg;

   localparam int W  = 16;
   localparam int RW = 3;

   // Same encodings as the downstream ALU.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_AND   = 2'b01;
   localparam logic [1:0] ALU_XOR   = 2'b10;
   localparam logic [1:0] ALU_PASSA = 2'b11;

   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   typedef struct packed {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [1:0]    op;
      logic [RW-1:0] dr;
      logic          wr_en;
   } ex_payload_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == STALL_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: MEM (non-load) over WB over register file,
// plus a flag telling the stage that the operand depends on an in-flight load.
module ex_operand_stage_fwd_mux
   import ex_operand_stage_pkg::*;
(
   input  logic [RW-1:0] spec_i,
   input  logic [W-1:0]  rf_val_i,
   input  logic          mem_valid_i,
   input  logic          mem_is_load_i,
   input  logic [RW-1:0] mem_dr_i,
   input  logic [W-1:0]  mem_data_i,
   input  logic          wb_valid_i,
   input  logic [RW-1:0] wb_dr_i,
   input  logic [W-1:0]  wb_data_i,
   output logic [W-1:0]  val_o,
   output logic          load_hit_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit    = mem_valid_i & (mem_dr_i == spec_i);
   assign wb_hit     = wb_valid_i & (wb_dr_i == spec_i);
   assign load_hit_o = mem_hit & mem_is_load_i;

   always_comb begin
      // NOTE: default first so every path assigns val_o and no latch is inferred.
      val_o = rf_val_i;
      if (mem_hit & ~mem_is_load_i) begin
         val_o = mem_data_i;
      end else if (wb_hit) begin
         val_o = wb_data_i;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// DE->EX pipeline register: captures one decoded instruction per handshake with
// operands forwarded at capture, back-pressures decode on load-use, counts stall cycles.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [RW-1:0] in_sr1,
   input  logic [RW-1:0] in_sr2,
   input  logic          in_use_sr1,
   input  logic          in_use_sr2,
   input  logic [W-1:0]  in_sr1_val,
   input  logic [W-1:0]  in_sr2_val,
   input  logic [W-1:0]  in_imm,
   input  logic          in_use_imm,
   input  logic [1:0]    in_op,
   input  logic [RW-1:0] in_dr,
   input  logic          in_wr_en,
   input  logic          mem_fwd_valid,
   input  logic          mem_fwd_is_load,
   input  logic [RW-1:0] mem_fwd_dr,
   input  logic [W-1:0]  mem_fwd_data,
   input  logic          wb_fwd_valid,
   input  logic [RW-1:0] wb_fwd_dr,
   input  logic [W-1:0]  wb_fwd_data,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [1:0]    alu_op,
   output logic [RW-1:0] out_dr,
   output logic          out_wr_en,
   output logic [15:0]   stall_cnt
);

   ex_payload_t   payload_q, payload_d;
   logic          out_valid_q, out_valid_d;
   logic [15:0]   stall_cnt_q;
   logic [W-1:0]  fwd_a, fwd_b;
   logic          hit_a, hit_b;
   logic          load_use;
   logic          accept;

   ex_operand_stage_fwd_mux u_fwd_a (
      .spec_i        (in_sr1),
      .rf_val_i      (in_sr1_val),
      .mem_valid_i   (mem_fwd_valid),
      .mem_is_load_i (mem_fwd_is_load),
      .mem_dr_i      (mem_fwd_dr),
      .mem_data_i    (mem_fwd_data),
      .wb_valid_i    (wb_fwd_valid),
      .wb_dr_i       (wb_fwd_dr),
      .wb_data_i     (wb_fwd_data),
      .val_o         (fwd_a),
      .load_hit_o    (hit_a)
   );

   ex_operand_stage_fwd_mux u_fwd_b (
      .spec_i        (in_sr2),
      .rf_val_i      (in_sr2_val),
      .mem_valid_i   (mem_fwd_valid),
      .mem_is_load_i (mem_fwd_is_load),
      .mem_dr_i      (mem_fwd_dr),
      .mem_data_i    (mem_fwd_data),
      .wb_valid_i    (wb_fwd_valid),
      .wb_dr_i       (wb_fwd_dr),
      .wb_data_i     (wb_fwd_data),
      .val_o         (fwd_b),
      .load_hit_o    (hit_b)
   );

   // SR2 is irrelevant to the hazard when operand B comes from the immediate.
   assign load_use = in_valid & ((in_use_sr1 & hit_a) |
                                 (in_use_sr2 & ~in_use_imm & hit_b));
   assign in_ready = (~out_valid_q | out_ready) & ~load_use & ~flush;
   assign accept   = in_valid & in_ready;

   always_comb begin
      payload_d.a     = in_use_sr1 ? fwd_a : in_sr1_val;
      payload_d.b     = in_use_imm ? in_imm : (in_use_sr2 ? fwd_b : in_sr2_val);
      payload_d.op    = in_op;
      payload_d.dr    = in_dr;
      payload_d.wr_en = in_wr_en;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         payload_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         if (accept) begin
            payload_q <= payload_d;
         end
         if (load_use & ~flush) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign alu_a     = payload_q.a;
   assign alu_b     = payload_q.b;
   assign alu_op    = payload_q.op;
   assign out_dr    = payload_q.dr;
   assign out_wr_en = payload_q.wr_en;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected payloads are queued at accept and
// compared when the stage presents them.
module tb_ex_operand_stage;
   import ex_operand_stage_pkg::*;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic [2:0]  dr;
      logic        wr;
   } exp_t;

   typedef struct packed {
      logic [2:0]  sr1, sr2;
      logic        u1, u2;
      logic [15:0] v1, v2;
      logic        mem_v;
      logic [2:0]  mem_dr;
      logic [15:0] mem_data;
      logic        wb_v;
      logic [2:0]  wb_dr;
      logic [15:0] wb_data;
      logic [15:0] exp_a, exp_b;
   } fwd_case_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [2:0]  in_sr1, in_sr2;
   logic        in_use_sr1, in_use_sr2;
   logic [15:0] in_sr1_val, in_sr2_val, in_imm;
   logic        in_use_imm;
   logic [1:0]  in_op;
   logic [2:0]  in_dr;
   logic        in_wr_en;
   logic        mem_fwd_valid, mem_fwd_is_load;
   logic [2:0]  mem_fwd_dr;
   logic [15:0] mem_fwd_data;
   logic        wb_fwd_valid;
   logic [2:0]  wb_fwd_dr;
   logic [15:0] wb_fwd_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [15:0] alu_a, alu_b;
   logic [1:0]  alu_op;
   logic [2:0]  out_dr;
   logic        out_wr_en;
   logic [15:0] stall_cnt;

   exp_t        got;
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   assign got = {alu_a, alu_b, alu_op, out_dr, out_wr_en};

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sr1(in_sr1), .in_sr2(in_sr2),
      .in_use_sr1(in_use_sr1), .in_use_sr2(in_use_sr2),
      .in_sr1_val(in_sr1_val), .in_sr2_val(in_sr2_val),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .in_op(in_op), .in_dr(in_dr), .in_wr_en(in_wr_en),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_is_load(mem_fwd_is_load),
      .mem_fwd_dr(mem_fwd_dr), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_dr(wb_fwd_dr), .wb_fwd_data(wb_fwd_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .out_dr(out_dr), .out_wr_en(out_wr_en),
      .stall_cnt(stall_cnt)
   );

   function automatic logic [15:0] fwd_model(input logic [2:0] sr, input logic [15:0] rf);
      if (mem_fwd_valid && !mem_fwd_is_load && mem_fwd_dr == sr) return mem_fwd_data;
      if (wb_fwd_valid && wb_fwd_dr == sr) return wb_fwd_data;
      return rf;
   endfunction

   function automatic exp_t model();
      exp_t e;
      e.a  = in_use_sr1 ? fwd_model(in_sr1, in_sr1_val) : in_sr1_val;
      e.b  = in_use_imm ? in_imm : (in_use_sr2 ? fwd_model(in_sr2, in_sr2_val) : in_sr2_val);
      e.op = in_op;
      e.dr = in_dr;
      e.wr = in_wr_en;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      in_valid = 1'b0; in_sr1 = '0; in_sr2 = '0; in_use_sr1 = 1'b0; in_use_sr2 = 1'b0;
      in_sr1_val = '0; in_sr2_val = '0; in_imm = '0; in_use_imm = 1'b0;
      in_op = ALU_ADD; in_dr = '0; in_wr_en = 1'b0;
      mem_fwd_valid = 1'b0; mem_fwd_is_load = 1'b0; mem_fwd_dr = '0; mem_fwd_data = '0;
      wb_fwd_valid = 1'b0; wb_fwd_dr = '0; wb_fwd_data = '0;
      flush = 1'b0; out_ready = 1'b1;
   endtask

   task automatic set_instr(input logic [2:0] sr1, input logic [2:0] sr2,
                            input logic [15:0] v1, input logic [15:0] v2,
                            input logic [1:0] op, input logic [2:0] dr);
      in_sr1 = sr1; in_sr2 = sr2; in_use_sr1 = 1'b1; in_use_sr2 = 1'b1;
      in_sr1_val = v1; in_sr2_val = v2; in_use_imm = 1'b0; in_imm = '0;
      in_op = op; in_dr = dr; in_wr_en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      tick();
      checks++;
      if (out_valid !== 1'b0 || got !== '0 || stall_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b payload=%h stall=%h, want 0/0/0", out_valid, got, stall_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_add();
      exp_t e;
      set_instr(3'd1, 3'd2, 16'h0005, 16'h0003, ALU_ADD, 3'd6);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", in_ready); end
      sb.push_back(model());
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
      e = sb.pop_front();
      checks++;
      if (got !== e) begin errors++; $display("FAIL add_payload: got %h want %h", got, e); end
      checks++;
      if (alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_op !== ALU_ADD) begin
         errors++;
         $display("FAIL add_operands: got a=%h b=%h op=%b want 0005/0003/00", alu_a, alu_b, alu_op);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed: got %b want 0", out_valid); end
   endtask

   task automatic test_forwarding();
      fwd_case_t cases[6];
      exp_t e;
      cases[0] = '{3'd3, 3'd5, 1'b1, 1'b1, 16'h1111, 16'h00FF, 1'b1, 3'd3, 16'h3333, 1'b1, 3'd3, 16'h2222, 16'h3333, 16'h00FF};
      cases[1] = '{3'd3, 3'd5, 1'b1, 1'b1, 16'h1111, 16'h00FF, 1'b0, 3'd3, 16'h3333, 1'b1, 3'd3, 16'h2222, 16'h2222, 16'h00FF};
      cases[2] = '{3'd3, 3'd5, 1'b1, 1'b1, 16'h1111, 16'h00FF, 1'b1, 3'd6, 16'h3333, 1'b1, 3'd7, 16'h2222, 16'h1111, 16'h00FF};
      cases[3] = '{3'd0, 3'd0, 1'b1, 1'b1, 16'h0AAA, 16'h0CCC, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0BBB, 16'h0BBB, 16'h0BBB};
      cases[4] = '{3'd3, 3'd3, 1'b0, 1'b1, 16'h1111, 16'h4444, 1'b1, 3'd3, 16'h3333, 1'b1, 3'd3, 16'h2222, 16'h1111, 16'h3333};
      cases[5] = '{3'd2, 3'd7, 1'b1, 1'b1, 16'h0001, 16'h0002, 1'b1, 3'd7, 16'h7777, 1'b1, 3'd2, 16'h2222, 16'h2222, 16'h7777};
      for (int i = 0; i < 6; i++) begin
         set_instr(cases[i].sr1, cases[i].sr2, cases[i].v1, cases[i].v2, 2'(i), 3'(i));
         in_use_sr1 = cases[i].u1; in_use_sr2 = cases[i].u2; in_wr_en = 1'(i);
         mem_fwd_valid = cases[i].mem_v; mem_fwd_is_load = 1'b0;
         mem_fwd_dr = cases[i].mem_dr; mem_fwd_data = cases[i].mem_data;
         wb_fwd_valid = cases[i].wb_v; wb_fwd_dr = cases[i].wb_dr; wb_fwd_data = cases[i].wb_data;
         in_valid = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd%0d_ready: got %b want 1", i, in_ready); end
         sb.push_back(model());
         tick();
         e = sb.pop_front();
         checks++;
         if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL fwd%0d_payload: valid=%b got %h want %h", i, out_valid, got, e);
         end
         checks++;
         if (alu_a !== cases[i].exp_a || alu_b !== cases[i].exp_b) begin
            errors++;
            $display("FAIL fwd%0d_operands: got a=%h b=%h want a=%h b=%h", i, alu_a, alu_b, cases[i].exp_a, cases[i].exp_b);
         end
      end
      drive_idle();
      tick();
   endtask

   task automatic test_load_use();
      exp_t e;
      set_instr(3'd1, 3'd4, 16'h0011, 16'h0044, ALU_XOR, 3'd2);
      mem_fwd_valid = 1'b1; mem_fwd_is_load = 1'b1; mem_fwd_dr = 3'd4; mem_fwd_data = 16'hDEAD;
      in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_c%0d: got %b want 0", c, in_ready); end
         tick();
      end
      checks++;
      if (stall_cnt !== 16'd2 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lu_stall2: got stall=%h valid=%b want 0002/0", stall_cnt, out_valid);
      end
      in_use_imm = 1'b1; in_imm = 16'hFFF0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_imm_ready: got %b want 1", in_ready); end
      sb.push_back(model());
      tick();
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got !== e || alu_b !== 16'hFFF0) begin
         errors++;
         $display("FAIL lu_imm_payload: valid=%b got %h want %h", out_valid, got, e);
      end
      checks++;
      if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_imm_nostall: got %h want 0002", stall_cnt); end
      in_sr1 = 3'd4;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_sr1_ready: got %b want 0", in_ready); end
      tick();
      checks++;
      if (stall_cnt !== 16'd3) begin errors++; $display("FAIL lu_sr1_stall: got %h want 0003", stall_cnt); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (stall_cnt !== 16'd3) begin errors++; $display("FAIL lu_flush_nocount: got %h want 0003", stall_cnt); end
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_novalid_ready: got %b want 1", in_ready); end
      tick();
      checks++;
      if (stall_cnt !== 16'd3) begin errors++; $display("FAIL lu_novalid_nocount: got %h want 0003", stall_cnt); end
      drive_idle();
      tick();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      set_instr(3'd1, 3'd2, 16'h00A1, 16'h00A2, ALU_AND, 3'd1);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_a_ready: got %b want 1", in_ready); end
      sb.push_back(model());
      tick();
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL bp_a_payload: got %h want %h", got, e); end
      out_ready = 1'b0;
      set_instr(3'd1, 3'd3, 16'h00B1, 16'h00B3, ALU_XOR, 3'd5);
      wb_fwd_valid = 1'b1; wb_fwd_dr = 3'd1; wb_fwd_data = 16'hBEEF;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready_c%0d: got %b want 0", c, in_ready); end
         checks++;
         if (out_valid !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL bp_hold_stable_c%0d: valid=%b got %h want %h", c, out_valid, got, e);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      sb.push_back(model());
      tick();
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got !== e || alu_a !== 16'hBEEF) begin
         errors++;
         $display("FAIL bp_b_payload: valid=%b got %h want %h", out_valid, got, e);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
      drive_idle();
   endtask

   task automatic test_flush_reset();
      exp_t e;
      set_instr(3'd6, 3'd7, 16'h0606, 16'h0707, ALU_PASSA, 3'd3);
      in_valid = 1'b1;
      #1;
      sb.push_back(model());
      tick();
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL fl_a_payload: got %h want %h", got, e); end
      out_ready = 1'b0; flush = 1'b1;
      set_instr(3'd2, 3'd2, 16'h2222, 16'h2222, ALU_ADD, 3'd4);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: got %b want 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_killed: got %b want 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_not_captured: got %b want 0", out_valid); end
      set_instr(3'd5, 3'd1, 16'h5555, 16'h1515, ALU_AND, 3'd7);
      in_valid = 1'b1;
      #1;
      sb.push_back(model());
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL rst_pre_payload: got %h want %h", got, e); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || got !== '0 || stall_cnt !== 16'h0) begin
         errors++;
         $display("FAIL rst_async: valid=%b payload=%h stall=%h want 0/0/0", out_valid, got, stall_cnt);
      end
      #1 rst = 1'b0;
      drive_idle();
      tick();
   endtask

   task automatic test_saturation();
      set_instr(3'd4, 3'd0, 16'h0, 16'h0, ALU_ADD, 3'd0);
      in_use_sr2 = 1'b0;
      mem_fwd_valid = 1'b1; mem_fwd_is_load = 1'b1; mem_fwd_dr = 3'd4;
      in_valid = 1'b1;
      repeat (65534) tick();
      checks++;
      if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt); end
      tick();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want ffff", stall_cnt); end
      repeat (5) tick();
      checks++;
      if (stall_cnt !== 16'hFFFF || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL sat_hold: got stall=%h ready=%b want ffff/0", stall_cnt, in_ready);
      end
      drive_idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_forwarding();
      test_load_use();
      test_back_to_back();
      test_flush_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
